// File: rtl/phyq_arb.sv
// ---------------------------------------------------------------------------
// phyq_arb : two-source frame arbiter feeding a single tx PHY FIFO.
//
// Two show-ahead source FIFOs carry 9-bit words (bit8 = end-of-frame).
// The arbiter grants one source per frame, alternates between sources when
// both are waiting, and streams the granted frame to the PHY FIFO. Frames are
// never interleaved; a stall (source empty or PHY full) holds the grant.
//
// Optional feature macro: PHYQ_ARB_TRUNC_EN
//   defined   : frames reaching MAX_LEN bytes without EOF are cut short; the
//               MAX_LEN-th word goes out with EOF forced, the rest of the
//               frame is popped and discarded (DRAIN), trunc_err is set.
//   undefined : no length limit, no DRAIN state, trunc_err tied low.
// ---------------------------------------------------------------------------
module phyq_arb #(
   parameter logic [10:0] MAX_LEN = 11'd1518
) (
   input  logic       pcie_clk,
   input  logic       sys_rst_n,
   input  logic [8:0] s0_dout,
   input  logic       s0_empty,
   output logic       s0_rd_en,
   input  logic [8:0] s1_dout,
   input  logic       s1_empty,
   output logic       s1_rd_en,
   output logic [8:0] phy_din,
   input  logic       phy_full,
   output logic       phy_wr_en,
   output logic [7:0] frm_cnt0,
   output logic [7:0] frm_cnt1,
   output logic       trunc_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
`ifdef PHYQ_ARB_TRUNC_EN
   localparam logic [1:0] ST_DRAIN = 2'd2;
`endif

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic        r_g;          // granted source
   logic        r_lp;         // last source that completed a frame
   logic [10:0] r_byte_cnt;
   logic [7:0]  r_frm_cnt0;
   logic [7:0]  r_frm_cnt1;

   logic        w_grant_valid;
   logic        w_grant_src;
   logic [8:0]  w_sel_dout;
   logic        w_sel_empty;
   logic        w_pop;
   logic        w_wr;
   logic        w_eof_pop;
   logic [10:0] w_cnt_inc;
`ifdef PHYQ_ARB_TRUNC_EN
   logic        w_trunc_hit;
   logic        r_trunc_err;
`else
   logic        w_unused_len;
`endif

   // Head word and empty flag of whichever source currently holds the grant
   assign w_sel_dout  = r_g ? s1_dout  : s0_dout;
   assign w_sel_empty = r_g ? s1_empty : s0_empty;
   assign w_cnt_inc   = r_byte_cnt + 11'd1;
   assign w_eof_pop   = w_pop && w_sel_dout[8];

`ifdef PHYQ_ARB_TRUNC_EN
   // A non-EOF pop that brings the frame to MAX_LEN bytes ends it early
   assign w_trunc_hit = (r_state == ST_XFER) && w_pop && !w_sel_dout[8]
                        && (w_cnt_inc == MAX_LEN);
`else
   // Length limit is inactive here; the counter is kept for observability
   assign w_unused_len = (w_cnt_inc == MAX_LEN);
`endif

   // Arbitration: alternate when both wait, otherwise take whoever has data
   always_comb begin
      w_grant_valid = !s0_empty || !s1_empty;
      if (!s0_empty && !s1_empty) begin
         w_grant_src = ~r_lp;
      end else if (!s0_empty) begin
         w_grant_src = 1'b0;
      end else begin
         w_grant_src = 1'b1;
      end
   end

   // State register
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: frames end only on EOF (or on truncation if enabled)
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_state_next = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_eof_pop) begin
               w_state_next = ST_IDLE;
`ifdef PHYQ_ARB_TRUNC_EN
            end else if (w_trunc_hit) begin
               w_state_next = ST_DRAIN;
`endif
            end
         end
`ifdef PHYQ_ARB_TRUNC_EN
         ST_DRAIN: begin
            if (w_eof_pop) begin
               w_state_next = ST_IDLE;
            end
         end
`endif
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Output logic: pop/write strobes; IDLE never pops (arbitration cycle)
   always_comb begin
      w_pop = 1'b0;
      w_wr  = 1'b0;
      case (r_state)
         ST_XFER: begin
            w_pop = !w_sel_empty && !phy_full;
            w_wr  = !w_sel_empty && !phy_full;
         end
`ifdef PHYQ_ARB_TRUNC_EN
         ST_DRAIN: begin
            // discard the truncated tail without touching the PHY FIFO
            w_pop = !w_sel_empty;
            w_wr  = 1'b0;
         end
`endif
         default: begin
            w_pop = 1'b0;
            w_wr  = 1'b0;
         end
      endcase
   end

   assign s0_rd_en  = w_pop && !r_g;
   assign s1_rd_en  = w_pop &&  r_g;
   assign phy_wr_en = w_wr;
`ifdef PHYQ_ARB_TRUNC_EN
   assign phy_din   = {w_sel_dout[8] | w_trunc_hit, w_sel_dout[7:0]};
`else
   assign phy_din   = w_sel_dout;
`endif

   // Grant register: latched in IDLE, held for the whole frame
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_g <= 1'b0;
      end else if (r_state == ST_IDLE && w_grant_valid) begin
         r_g <= w_grant_src;
      end
   end

   // Last-served pointer: updated when a frame ends (EOF or truncation)
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_lp <= 1'b1;
      end else if (r_state == ST_XFER && w_eof_pop) begin
         r_lp <= r_g;
`ifdef PHYQ_ARB_TRUNC_EN
      end else if (w_trunc_hit) begin
         r_lp <= r_g;
`endif
      end
   end

   // Byte counter: cleared when a frame is granted, counts every granted pop
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_byte_cnt <= 11'd0;
      end else if (r_state == ST_IDLE && w_grant_valid) begin
         r_byte_cnt <= 11'd0;
      end else if (w_pop) begin
         r_byte_cnt <= w_cnt_inc;
      end
   end

   // Completed-frame counters; only genuine EOFs in XFER count (wrap at 255)
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_frm_cnt0 <= 8'd0;
         r_frm_cnt1 <= 8'd0;
      end else if (r_state == ST_XFER && w_eof_pop) begin
         if (r_g) begin
            r_frm_cnt1 <= r_frm_cnt1 + 8'd1;
         end else begin
            r_frm_cnt0 <= r_frm_cnt0 + 8'd1;
         end
      end
   end

   assign frm_cnt0 = r_frm_cnt0;
   assign frm_cnt1 = r_frm_cnt1;

`ifdef PHYQ_ARB_TRUNC_EN
   // Sticky truncation flag, cleared only by reset
   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_trunc_err <= 1'b0;
      end else if (w_trunc_hit) begin
         r_trunc_err <= 1'b1;
      end
   end
   assign trunc_err = r_trunc_err;
`else
   assign trunc_err = 1'b0;
`endif

endmodule

// File: tb/tb_phyq_arb.sv
// ---------------------------------------------------------------------------
// tb_phyq_arb : directed self-checking bench for phyq_arb (MAX_LEN = 16).
// Source FIFOs are modelled as show-ahead queues; PHY writes are logged with
// the cycle index at which they were sampled.
// ---------------------------------------------------------------------------
module tb_phyq_arb;

   logic       pcie_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [8:0] s0_dout = 9'h0;
   logic       s0_empty = 1'b1;
   logic       s0_rd_en;
   logic [8:0] s1_dout = 9'h0;
   logic       s1_empty = 1'b1;
   logic       s1_rd_en;
   logic [8:0] phy_din;
   logic       phy_full = 1'b0;
   logic       phy_wr_en;
   logic [7:0] frm_cnt0;
   logic [7:0] frm_cnt1;
   logic       trunc_err;

   int checks = 0;
   int errors = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] wr_q[$];
   int         wr_cyc[$];
   int         rd0_cyc[$];
   int         rd1_n = 0;
   int         cyc = 0;
   int         rel_cyc = 0;
   logic       p0, p1;

   phyq_arb #(.MAX_LEN(11'd16)) dut (
      .pcie_clk  (pcie_clk),
      .sys_rst_n (sys_rst_n),
      .s0_dout   (s0_dout),
      .s0_empty  (s0_empty),
      .s0_rd_en  (s0_rd_en),
      .s1_dout   (s1_dout),
      .s1_empty  (s1_empty),
      .s1_rd_en  (s1_rd_en),
      .phy_din   (phy_din),
      .phy_full  (phy_full),
      .phy_wr_en (phy_wr_en),
      .frm_cnt0  (frm_cnt0),
      .frm_cnt1  (frm_cnt1),
      .trunc_err (trunc_err)
   );

   always #5 pcie_clk = ~pcie_clk;

   task automatic refresh();
      s0_empty = (q0.size() == 0);
      s0_dout  = s0_empty ? 9'h000 : q0[0];
      s1_empty = (q1.size() == 0);
      s1_dout  = s1_empty ? 9'h000 : q1[0];
   endtask

   // Source/sink model: sample strobes on the falling edge, pop after rising edge
   always begin
      @(negedge pcie_clk);
      cyc++;
      p0 = s0_rd_en;
      p1 = s1_rd_en;
      if (phy_wr_en) begin
         wr_q.push_back(phy_din);
         wr_cyc.push_back(cyc);
      end
      if (p0) rd0_cyc.push_back(cyc);
      if (p1) rd1_n++;
      @(posedge pcie_clk);
      #1;
      if (p0 && q0.size() > 0) q0.delete(0);
      if (p1 && q1.size() > 0) q1.delete(0);
      refresh();
   end

   task automatic step();
      @(posedge pcie_clk);
      #2;
   endtask

   task automatic load(input bit src, input logic [8:0] w);
      if (src) q1.push_back(w);
      else     q0.push_back(w);
      refresh();
   endtask

   task automatic clear_logs();
      wr_q.delete();
      wr_cyc.delete();
      rd0_cyc.delete();
      rd1_n = 0;
   endtask

   task automatic start_reset();
      sys_rst_n = 1'b0;
      phy_full  = 1'b0;
      q0.delete();
      q1.delete();
      refresh();
      clear_logs();
      step();
   endtask

   task automatic release_reset();
      sys_rst_n = 1'b1;
      rel_cyc   = cyc;
   endtask

   task automatic wait_writes(input int n, input string name);
      int k = 0;
      while (wr_q.size() < n && k < 300) begin
         step();
         k++;
      end
      checks++;
      if (wr_q.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wr_q.size(), n);
      end
   endtask

   task automatic test_reset();
      start_reset();
      checks++; if (s0_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_s0_rd_en: got %b expected 0", s0_rd_en); end
      checks++; if (s1_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_s1_rd_en: got %b expected 0", s1_rd_en); end
      checks++; if (phy_wr_en !== 1'b0) begin errors++; $display("FAIL rst_phy_wr_en: got %b expected 0", phy_wr_en); end
      checks++; if (frm_cnt0 !== 8'd0)  begin errors++; $display("FAIL rst_frm_cnt0: got %0d expected 0", frm_cnt0); end
      checks++; if (frm_cnt1 !== 8'd0)  begin errors++; $display("FAIL rst_frm_cnt1: got %0d expected 0", frm_cnt1); end
      checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL rst_trunc_err: got %b expected 0", trunc_err); end
      // data waiting while reset is held must not be popped
      load(1'b0, 9'h011); load(1'b0, 9'h022); load(1'b0, 9'h033); load(1'b0, 9'h1AA);
      step();
      checks++; if (s0_rd_en !== 1'b0) begin errors++; $display("FAIL rst_hold_rd: got %b expected 0", s0_rd_en); end
      release_reset();
      @(negedge pcie_clk); #1;
      checks++; if (s0_rd_en !== 1'b0) begin errors++; $display("FAIL first_cycle_rd: got %b expected 0", s0_rd_en); end
      @(negedge pcie_clk); #1;
      checks++; if (s0_rd_en !== 1'b1) begin errors++; $display("FAIL second_cycle_rd: got %b expected 1", s0_rd_en); end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_single_frame();
      logic [8:0] exp_w[4] = '{9'h011, 9'h022, 9'h033, 9'h1AA};
      wait_writes(4, "single");
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== exp_w[i]) begin
            errors++; $display("FAIL single_word%0d: got %h expected %h", i, wr_q[i], exp_w[i]);
         end
         checks++;
         if (wr_cyc[i] !== rel_cyc + 2 + i) begin
            errors++; $display("FAIL single_cycle%0d: got %0d expected %0d", i, wr_cyc[i], rel_cyc + 2 + i);
         end
      end
      step();
      checks++; if (frm_cnt0 !== 8'd1) begin errors++; $display("FAIL single_frm_cnt0: got %0d expected 1", frm_cnt0); end
      checks++; if (frm_cnt1 !== 8'd0) begin errors++; $display("FAIL single_frm_cnt1: got %0d expected 0", frm_cnt1); end
      $display("test_single_frame done: writes=%0d checks=%0d errors=%0d", wr_q.size(), checks, errors);
   endtask

   task automatic test_two_sources();
      logic [8:0] exp_w[10] = '{9'h0A0, 9'h0A1, 9'h1A2, 9'h0B0, 9'h1B1,
                                9'h0C0, 9'h1C1, 9'h0D0, 9'h0D1, 9'h1D2};
      start_reset();
      load(1'b0, 9'h0A0); load(1'b0, 9'h0A1); load(1'b0, 9'h1A2);
      load(1'b0, 9'h0C0); load(1'b0, 9'h1C1);
      load(1'b1, 9'h0B0); load(1'b1, 9'h1B1);
      load(1'b1, 9'h0D0); load(1'b1, 9'h0D1); load(1'b1, 9'h1D2);
      step();
      release_reset();
      wait_writes(10, "two_src");
      for (int i = 0; i < 10 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== exp_w[i]) begin
            errors++; $display("FAIL two_src_word%0d: got %h expected %h", i, wr_q[i], exp_w[i]);
         end
      end
      // one idle arbitration cycle between consecutive frames
      if (wr_cyc.size() >= 10) begin
         checks++; if (wr_cyc[3] !== wr_cyc[2] + 2) begin errors++; $display("FAIL gap_AB: got %0d expected %0d", wr_cyc[3], wr_cyc[2] + 2); end
         checks++; if (wr_cyc[5] !== wr_cyc[4] + 2) begin errors++; $display("FAIL gap_BC: got %0d expected %0d", wr_cyc[5], wr_cyc[4] + 2); end
         checks++; if (wr_cyc[7] !== wr_cyc[6] + 2) begin errors++; $display("FAIL gap_CD: got %0d expected %0d", wr_cyc[7], wr_cyc[6] + 2); end
      end
      step();
      checks++; if (frm_cnt0 !== 8'd2) begin errors++; $display("FAIL two_src_frm_cnt0: got %0d expected 2", frm_cnt0); end
      checks++; if (frm_cnt1 !== 8'd2) begin errors++; $display("FAIL two_src_frm_cnt1: got %0d expected 2", frm_cnt1); end
      $display("test_two_sources done: writes=%0d checks=%0d errors=%0d", wr_q.size(), checks, errors);
   endtask

   task automatic test_trunc();
      int k = 0;
      clear_logs();
      for (int i = 0; i < 20; i++) begin
         load(1'b1, {(i == 19), 8'h40 + 8'(i)});
      end
      while (q1.size() != 0 && k < 300) begin
         step();
         k++;
      end
      checks++; if (q1.size() != 0) begin errors++; $display("FAIL trunc_drain_timeout: got %0d left expected 0", q1.size()); end
      step(); step(); step();
      checks++; if (rd1_n !== 20) begin errors++; $display("FAIL trunc_pops: got %0d expected 20", rd1_n); end
`ifdef PHYQ_ARB_TRUNC_EN
      checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL trunc_writes: got %0d expected 16", wr_q.size()); end
      for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== {(i == 15), 8'h40 + 8'(i)}) begin
            errors++; $display("FAIL trunc_word%0d: got %h expected %h", i, wr_q[i], {(i == 15), 8'h40 + 8'(i)});
         end
      end
      checks++; if (trunc_err !== 1'b1) begin errors++; $display("FAIL trunc_err_set: got %b expected 1", trunc_err); end
      checks++; if (frm_cnt1 !== 8'd2) begin errors++; $display("FAIL trunc_frm_cnt1: got %0d expected 2", frm_cnt1); end
`else
      checks++; if (wr_q.size() !== 20) begin errors++; $display("FAIL long_writes: got %0d expected 20", wr_q.size()); end
      for (int i = 0; i < 20 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== {(i == 19), 8'h40 + 8'(i)}) begin
            errors++; $display("FAIL long_word%0d: got %h expected %h", i, wr_q[i], {(i == 19), 8'h40 + 8'(i)});
         end
      end
      checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL long_trunc_err: got %b expected 0", trunc_err); end
      checks++; if (frm_cnt1 !== 8'd3) begin errors++; $display("FAIL long_frm_cnt1: got %0d expected 3", frm_cnt1); end
`endif
      $display("test_trunc done: writes=%0d pops=%0d checks=%0d errors=%0d", wr_q.size(), rd1_n, checks, errors);
   endtask

   task automatic test_reset_midframe();
      logic [8:0] exp_w[4] = '{9'h0E0, 9'h1E1, 9'h0F0, 9'h1F1};
      clear_logs();
      for (int i = 0; i < 5; i++) load(1'b0, {(i == 4), 8'h50 + 8'(i)});
      load(1'b1, 9'h070); load(1'b1, 9'h171);
      wait_writes(2, "mid_pre");
      sys_rst_n = 1'b0;
      #1;
      checks++; if (s0_rd_en !== 1'b0)  begin errors++; $display("FAIL mid_s0_rd_en: got %b expected 0", s0_rd_en); end
      checks++; if (s1_rd_en !== 1'b0)  begin errors++; $display("FAIL mid_s1_rd_en: got %b expected 0", s1_rd_en); end
      checks++; if (phy_wr_en !== 1'b0) begin errors++; $display("FAIL mid_phy_wr_en: got %b expected 0", phy_wr_en); end
      checks++; if (frm_cnt0 !== 8'd0)  begin errors++; $display("FAIL mid_frm_cnt0: got %0d expected 0", frm_cnt0); end
      checks++; if (frm_cnt1 !== 8'd0)  begin errors++; $display("FAIL mid_frm_cnt1: got %0d expected 0", frm_cnt1); end
      checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL mid_trunc_err: got %b expected 0", trunc_err); end
      checks++; if (wr_q.size() !== 2)  begin errors++; $display("FAIL mid_abandon_cnt: got %0d expected 2", wr_q.size()); end
      if (wr_q.size() >= 2) begin
         checks++; if (wr_q[1] !== 9'h051) begin errors++; $display("FAIL mid_no_eof: got %h expected 051", wr_q[1]); end
      end
      start_reset();
      load(1'b0, 9'h0E0); load(1'b0, 9'h1E1);
      load(1'b1, 9'h0F0); load(1'b1, 9'h1F1);
      step();
      release_reset();
      wait_writes(4, "mid_post");
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== exp_w[i]) begin
            errors++; $display("FAIL mid_restart_word%0d: got %h expected %h", i, wr_q[i], exp_w[i]);
         end
      end
      if (wr_cyc.size() >= 1) begin
         checks++; if (wr_cyc[0] !== rel_cyc + 2) begin errors++; $display("FAIL mid_restart_latency: got %0d expected %0d", wr_cyc[0], rel_cyc + 2); end
      end
      $display("test_reset_midframe done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_backpressure();
      clear_logs();
      for (int i = 0; i < 6; i++) load(1'b0, {(i == 5), 8'h60 + 8'(i)});
      wait_writes(2, "bp_pre");
      phy_full = 1'b1;
      step();
      checks++; if (phy_wr_en !== 1'b0) begin errors++; $display("FAIL bp_wr_while_full: got %b expected 0", phy_wr_en); end
      checks++; if (s0_rd_en !== 1'b0)  begin errors++; $display("FAIL bp_rd_while_full: got %b expected 0", s0_rd_en); end
      step(); step();
      phy_full = 1'b0;
      wait_writes(6, "bp_post");
      step();
      checks++; if (wr_q.size() !== 6) begin errors++; $display("FAIL bp_writes: got %0d expected 6", wr_q.size()); end
      for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i] !== {(i == 5), 8'h60 + 8'(i)}) begin
            errors++; $display("FAIL bp_word%0d: got %h expected %h", i, wr_q[i], {(i == 5), 8'h60 + 8'(i)});
         end
      end
      if (wr_cyc.size() >= 6) begin
         checks++; if (wr_cyc[1] !== wr_cyc[0] + 1) begin errors++; $display("FAIL bp_cyc1: got %0d expected %0d", wr_cyc[1], wr_cyc[0] + 1); end
         checks++; if (wr_cyc[2] !== wr_cyc[1] + 4) begin errors++; $display("FAIL bp_stall_len: got %0d expected %0d", wr_cyc[2], wr_cyc[1] + 4); end
         checks++; if (wr_cyc[5] !== wr_cyc[2] + 3) begin errors++; $display("FAIL bp_resume: got %0d expected %0d", wr_cyc[5], wr_cyc[2] + 3); end
      end
      checks++; if (rd0_cyc.size() !== 6) begin errors++; $display("FAIL bp_pops: got %0d expected 6", rd0_cyc.size()); end
      for (int i = 0; i < 6 && i < rd0_cyc.size() && i < wr_cyc.size(); i++) begin
         checks++;
         if (rd0_cyc[i] !== wr_cyc[i]) begin
            errors++; $display("FAIL bp_rd_wr_align%0d: got %0d expected %0d", i, rd0_cyc[i], wr_cyc[i]);
         end
      end
      checks++; if (frm_cnt0 !== 8'd2) begin errors++; $display("FAIL bp_frm_cnt0: got %0d expected 2", frm_cnt0); end
      $display("test_backpressure done: writes=%0d checks=%0d errors=%0d", wr_q.size(), checks, errors);
   endtask

   initial begin
      refresh();
      test_reset();
      test_single_frame();
      test_two_sources();
      test_trunc();
      test_reset_midframe();
      test_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
